// File: rtl/pwm_duty_ramp_pkg.sv
// pwm_pkg: shared state encoding and default widths for the PWM block family
package pwm_pkg;
    localparam int PWM_R = 8;
    localparam int PWM_PRESC_W = 16;
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_e;
endpackage

// File: rtl/pwm_duty_ramp_if.sv
// pwm_duty_ramp_if: target/step/rate offer with valid/ready handshake
interface pwm_duty_ramp_if #(parameter int R = 8, parameter int PRESC_W = 16);
    logic               tgt_valid;
    logic               tgt_ready;
    logic [R-1:0]       target;
    logic [R-1:0]       step;
    logic [PRESC_W-1:0] rate;
    modport master(output tgt_valid, target, step, rate, input tgt_ready);
    modport slave(input tgt_valid, target, step, rate, output tgt_ready);
endinterface

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: free-running R-bit PWM period counter with wrap and start decodes
module pwm_period_counter #(parameter int R = 8) (
    input  logic         clk,
    input  logic         reset,
    output logic [R-1:0] pcnt,
    output logic         wrap,
    output logic         period_start
);
    logic [R-1:0] pcnt_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) pcnt_q <= '0;
        else       pcnt_q <= pcnt_q + 1'b1;
    assign pcnt         = pcnt_q;
    assign wrap         = &pcnt_q;
    assign period_start = pcnt_q == '0;
endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slews duty toward an accepted target, one step per (rate+1) PWM periods
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int R       = PWM_R,
    parameter int PRESC_W = PWM_PRESC_W
) (
    input  logic          clk,
    input  logic          reset,
    pwm_duty_ramp_if.slave tgt,
    output logic [R-1:0]  duty,
    output logic          busy,
    output logic          done,
    output logic          period_start
);
    state_e             state_q, state_d;
    logic [R-1:0]       duty_q, duty_d, tgt_q, tgt_d, step_q, step_d;
    logic [PRESC_W-1:0] rate_q, rate_d, rcnt_q, rcnt_d;
    logic               done_q, done_d, wrap, accept;
    logic [R:0]         sum;
    logic signed [R:0]  diff;
    logic [R-1:0]       up_nxt, dn_nxt;

    pwm_period_counter #(.R(R)) u_pcnt (
        .clk(clk), .reset(reset), .pcnt(), .wrap(wrap), .period_start(period_start)
    );

    assign accept        = tgt.tgt_valid && tgt.tgt_ready;
    assign tgt.tgt_ready = state_q == IDLE;
    assign busy          = state_q != IDLE;
    assign duty          = duty_q;
    assign done          = done_q;
    // R+1-bit arithmetic so the clamp sees carries/borrows instead of wrapping
    assign sum    = {1'b0, duty_q} + {1'b0, step_q};
    assign diff   = $signed({1'b0, duty_q}) - $signed({1'b0, step_q});
    assign up_nxt = sum > {1'b0, tgt_q} ? tgt_q : sum[R-1:0];
    assign dn_nxt = diff < $signed({1'b0, tgt_q}) ? tgt_q : diff[R-1:0];

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        rate_d  = rate_q;
        rcnt_d  = rcnt_q;
        done_d  = 1'b0;
        if (accept) begin
            tgt_d   = tgt.target;
            step_d  = tgt.step == '0 ? R'(1) : tgt.step;
            rate_d  = tgt.rate;
            rcnt_d  = tgt.rate;
            state_d = tgt.target > duty_q ? UP : tgt.target < duty_q ? DOWN : IDLE;
            done_d  = tgt.target == duty_q;
        end else if (state_q != IDLE && wrap) begin
            if (rcnt_q == '0) begin
                duty_d = state_q == UP ? up_nxt : dn_nxt;
                rcnt_d = rate_q;
                if (duty_d == tgt_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                rcnt_d = rcnt_q - PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            rate_q  <= '0;
            rcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            rate_q  <= rate_d;
            rcnt_q  <= rcnt_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Upstream duty-cycle source for the basic PWM stage. It accepts a target duty word over a valid/ready handshake and slews its `duty` output toward that target in programmable steps at a programmable rate. Every `duty` change is aligned to the PWM period boundary, so the downstream comparator never sees a mid-period glitch. It keeps an internal period counter that mirrors the PWM stage's free-running R-bit counter; both stages must leave reset together.

## Interface
Parameters:
- `R`, 8: duty and period-counter width; must match the downstream PWM stage.
- `PRESC_W`, 16: width of the rate (periods-per-step) field.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `tgt_valid`  in  1: a new target, step and rate are offered.
- `tgt_ready`  out  1: the block can accept a target (high only in IDLE).
- `target`  in  R: requested final duty.
- `step`  in  R: duty increment per step; a value of 0 is treated as 1.
- `rate`  in  PRESC_W: number of PWM periods per step, minus 1.
- `duty`  out  R: registered duty word feeding the PWM stage.
- `busy`  out  1: the block is ramping (state is not IDLE).
- `done`  out  1: one-cycle pulse when `duty` reaches `target`.
- `period_start`  out  1: high while the internal period counter is 0.

## Operation
- Period counter `pcnt` (R bits):
  - Reset value 0; increments every cycle and wraps from 2^R-1 to 0.
  - `wrap` is the cycle where `pcnt` equals 2^R-1.
- States:
  - IDLE → UP when a target is accepted and `target` > `duty`.
  - IDLE → DOWN when a target is accepted and `target` < `duty`.
  - UP or DOWN → IDLE on the step that lands `duty` on the target.
- Accept: `tgt_valid` && `tgt_ready` at a rising edge.
  - On accept, latch `target`, `max(step,1)` and `rate`, and load the rate counter `rcnt` with `rate`.
  - `tgt_valid` while busy is ignored; nothing is latched.
- Accept with `target` equal to `duty`: stay in IDLE, pulse `done` the next cycle, leave `duty` unchanged.
- Rate logic, applied at each `wrap` while in UP or DOWN:
  - If `rcnt` is 0: apply one step and reload `rcnt` with the latched rate.
  - Otherwise: decrement `rcnt`.
- Step arithmetic is done in R+1 bits with no overshoot and no wrap:
  - UP: `duty` ← `min(duty+step, target)`.
  - DOWN: `duty` ← `max(duty-step, target)`; the subtraction is done as signed R+1.
- Full-scale endpoints 2^R-1 and 0 are reachable exactly.
- `done` goes high on the same edge that writes the final `duty`, for one cycle. At that edge the state returns to IDLE and `tgt_ready` rises.
- Reset values: `duty`=0, `pcnt`=0, state IDLE, `rcnt`=0, `busy`=0, `done`=0, `tgt_ready`=1.
- `period_start` is 1 while `pcnt`=0, which is immediately true after reset.
- Reset asserted mid-ramp forces all reset values immediately (asynchronously). The latched target is discarded.

## Timing
- `duty` changes only on the edge where `pcnt` goes from 2^R-1 to 0. The new value is valid from the first cycle of the new PWM period.
- First step latency: the (rate+1)-th `wrap` after the accept edge.
- An accept on the same cycle as a `wrap` does not count that `wrap`.
- `tgt_ready` and `busy` are registered state decodes and change on the edge after the accept.
- The number of steps to the target is ceil(|target−duty|/step).
- The total ramp time is roughly steps × (rate+1) × 2^R cycles.
- `period_start` is a combinational decode of registered `pcnt`, so it has no added latency.

## Structure
- Shared package `pwm_pkg` holds:
  - the state enumeration (IDLE, UP, DOWN);
  - the default `R` and `PRESC_W` constants used by all PWM-family blocks.
- One sub-module, `pwm_period_counter`, provides:
  - the R-bit free-running counter with outputs `pcnt`, `wrap` and `period_start`;
  - reuse by the PWM stage and by any future phase-aligned PWM blocks.
- Top level contains the FSM, the latch registers, `rcnt`, and the step datapath.

## Test plan
- Reset, then release → `duty`=0, `tgt_ready`=1, `busy`=0, `period_start` high in the first cycle.
- From duty 0, accept target=100, step=10, rate=0 → `duty` takes 10, 20, …, 100 on 10 consecutive wraps (256-cycle spacing). `done` pulses together with `duty`=100; `busy` falls on the same edge.
- From duty 100, accept target=105, step=10 → `duty`=105 on the first wrap (clamped, no overshoot) and `done` pulses. Also, from duty 0, target=255 with step=0 (treated as 1) → 255 steps and final `duty`=255.
- From duty 105, accept target=0, step=50, rate=2 → `duty` is 55 after the 3rd wrap, 5 after the 6th, and 0 after the 9th, with no underflow. `tgt_valid` pulsed mid-ramp is ignored.
- Accept target equal to the current `duty` (e.g. 0) → `done` pulses the next cycle; `duty` is unchanged and `busy` stays 0.
- Reset asserted halfway through the ramp from the second scenario (`duty`=50) → `duty`=0, `busy`=0, `pcnt`=0 without waiting for a clock edge. After release, a new accept ramps correctly.
